// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard / stall controller for the ID stage of the 5-stage pipeline.
// It detects a load in EX whose destination feeds the ID-stage instruction.
// It then holds PC and IF/ID and zeroes the control for LU_STALLS cycles.
// A taken branch flushes IF/ID only when no stall is in progress.
// A saturating counter records the number of cycles with the PC held.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LU_STALLS  = 1,
    parameter int IGNORE_R0  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ID_EX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRd_i,
    input  logic [REG_ADDR_W-1:0] IF_ID_RS_i,
    input  logic [REG_ADDR_W-1:0] IF_ID_RT_i,
    input  logic                  IF_ID_UsesRT_i,
    input  logic                  Branch_taken_i,
    output logic                  mux8_o,
    output logic                  IF_ID_write_o,
    output logic                  PC_write_o,
    output logic                  IF_ID_flush_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    // FSM encoding. HOLD covers the extra bubbles after the first stall cycle.
    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    // Remaining HOLD cycles loaded on hazard entry.
    // The first stall cycle happens in RUN.
    localparam logic [3:0] REM_LOAD = 4'(LU_STALLS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             state_q, state_d;
    logic [3:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rd_valid;
    logic rs_match;
    logic rt_match;
    logic haz;
    logic stall_now;

    // Hazard term.
    // A destination of r0 is ignored when IGNORE_R0 is set.
    // An rt match counts only if the ID instruction actually reads rt.
    always_comb begin
        rd_valid = !((IGNORE_R0 != 0) && (ID_EX_RegisterRd_i == '0));
        rs_match = (ID_EX_RegisterRd_i == IF_ID_RS_i);
        rt_match = (ID_EX_RegisterRd_i == IF_ID_RT_i);
        haz      = ID_EX_MemRead_i && rd_valid && (rs_match || (IF_ID_UsesRT_i && rt_match));
    end

    // Stall in the same cycle a hazard is seen in RUN.
    // Also stall unconditionally in HOLD, because the bubble is already in EX.
    always_comb begin
        stall_now = ((state_q == ST_RUN) && haz) || (state_q == ST_HOLD);
    end

    // Pipeline control outputs. Reset forces the pass-through pattern.
    // A stall masks the flush because the branch operands are stale.
    always_comb begin
        if (rst_i) begin
            mux8_o        = 1'b1;
            IF_ID_write_o = 1'b1;
            PC_write_o    = 1'b1;
            IF_ID_flush_o = 1'b0;
        end else begin
            mux8_o        = !stall_now;
            IF_ID_write_o = !stall_now;
            PC_write_o    = !stall_now;
            IF_ID_flush_o = Branch_taken_i && !stall_now;
        end
    end

    // Next state and bubble countdown.
    // The HOLD cycle with rem==1 is the last stall cycle.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_RUN: begin
                if (haz && (LU_STALLS > 1)) begin
                    state_d = ST_HOLD;
                    rem_d   = REM_LOAD;
                end
            end
            ST_HOLD: begin
                if (rem_q <= 4'd1) begin
                    state_d = ST_RUN;
                    rem_d   = 4'd0;
                end else begin
                    rem_d = rem_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                rem_d   = 4'd0;
            end
        endcase
    end

    // Saturating count of cycles with the PC held.
    always_comb begin
        cnt_d = cnt_q;
        if (!PC_write_o && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers.
    // Reset abandons any stall in progress and clears the counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            rem_q   <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised successor to the pipeline's load-use hazard detector. Sits in the ID stage of the 5-stage pipelined CPU.
- Drives the control-zeroing mux select, the IF/ID write enable, the PC write enable and the IF/ID flush.
- Adds three things the earlier detector lacks: configurable multi-cycle load-use stalls for slower data memory, r0 and unused-rt filtering, and branch-flush arbitration.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, width of register-address fields.
- LU_STALLS, 1, bubble cycles inserted per load-use hazard (1..15).
- IGNORE_R0, 1, when 1 a destination of register 0 never causes a hazard.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk_i  in  1  pipeline clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- ID_EX_RegisterRd_i  in  REG_ADDR_W  destination register of the EX-stage load.
- IF_ID_RS_i  in  REG_ADDR_W  rs field of the ID-stage instruction.
- IF_ID_RT_i  in  REG_ADDR_W  rt field of the ID-stage instruction.
- IF_ID_UsesRT_i  in  1  ID-stage instruction reads rt; 0 for I-type ALU ops, loads and jumps.
- Branch_taken_i  in  1  branch resolved taken in ID this cycle.
- mux8_o  out  1  1 = pass control to ID/EX; 0 = insert bubble.
- IF_ID_write_o  out  1  IF/ID register write enable.
- PC_write_o  out  1  PC write enable.
- IF_ID_flush_o  out  1  clear IF/ID on the next edge.
- stall_cnt_o  out  CNT_W  stalled-cycle count.

Behaviour:
- Hazard term (combinational):
  - haz = ID_EX_MemRead_i & rd_valid & (Rd==RS | (IF_ID_UsesRT_i & Rd==RT)).
  - rd_valid = ~(IGNORE_R0 & Rd==0).
- State machine: RUN and HOLD, with a 4-bit down-counter rem.
- RUN:
  - haz=1: stall this same cycle (mux8_o=0, IF_ID_write_o=0, PC_write_o=0, zero added latency).
  - haz=1 and LU_STALLS>1: next state HOLD, rem=LU_STALLS-1.
  - haz=1 and LU_STALLS=1: stay in RUN.
  - haz=0: all three enables 1.
- HOLD:
  - Stall outputs asserted every cycle regardless of haz; the bubble is already in EX, so haz may drop.
  - rem decrements each cycle.
  - The cycle with rem==1 is the last stall cycle; next state RUN.
  - Total stalled cycles per hazard = LU_STALLS exactly.
- Flush:
  - IF_ID_flush_o = Branch_taken_i & ~stall_now, where stall_now = (RUN & haz) | HOLD.
  - A stall suppresses the flush because branch operands are stale; the branch re-resolves once the stall clears.
- Back-to-back hazards: when RUN is re-entered and haz=1 again, a new full stall sequence starts immediately, with no pass cycle in between.
- stall_cnt_o:
  - Increments on each edge where PC_write_o==0.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Reset:
  - rst_i=1 at an edge: state=RUN, rem=0, stall_cnt_o=0.
  - While rst_i=1, outputs are forced to mux8_o=1, IF_ID_write_o=1, PC_write_o=1, IF_ID_flush_o=0, whatever the other inputs.
  - Reset during HOLD aborts the stall; the first post-reset cycle evaluates haz fresh.
- All outputs are defined, with no X, for all input combinations once out of reset.

Test Plan:
- LU_STALLS=1: lw $3 in EX, ID reads rs=$3 -> exactly 1 cycle with mux8_o/IF_ID_write_o/PC_write_o=0; stall_cnt_o=1 afterwards.
- LU_STALLS=3: same hazard; haz drops after cycle 1 -> stall held 3 consecutive cycles, then RUN; stall_cnt_o=3.
- Filtering:
  - Rd=0 with RS=0 and IGNORE_R0=1 -> no stall.
  - Rd=$5, RT=$5, IF_ID_UsesRT_i=0 -> no stall.
  - Same with IF_ID_UsesRT_i=1 -> stall.
- Branch_taken_i=1 with no hazard -> IF_ID_flush_o=1 for that cycle.
- Branch_taken_i=1 during a stall cycle -> IF_ID_flush_o=0, PC_write_o=0.
- rst_i asserted in the 2nd cycle of a 3-cycle HOLD -> outputs pass during reset, state RUN, stall_cnt_o=0 after the edge, no residual stall.
- CNT_W=4: 20 stall cycles -> stall_cnt_o stops at 15.
